// File: rtl/ts_input_sync_fifo.sv
// TS input stage: locks to 0x47 sync at 188-byte spacing and buffers locked bytes,
// each tagged with its packet position, in a FIFO for the T2-MI packer.
module ts_input_sync_fifo #(
    parameter int unsigned ADDR_W       = 11,
    parameter int unsigned LOCK_COUNT   = 3,
    parameter int unsigned UNLOCK_COUNT = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [7:0]        TS_DATA,
    input  logic              TS_VALID,
    input  logic              RD_REQ,
    output logic [7:0]        DATA,
    output logic [7:0]        BYTE_INDEX,
    output logic              EMPTY,
    output logic              SYNC_FOUND,
    output logic              OVERFLOW,
    output logic              SYNC_ERR,
    output logic [ADDR_W:0]   FILL_LEVEL
);

    localparam logic [7:0]      SYNC_BYTE = 8'h47;
    localparam logic [7:0]      PKT_LEN   = 8'd188;
    localparam logic [7:0]      LOCK_N    = 8'(LOCK_COUNT);
    localparam logic [7:0]      UNLOCK_N  = 8'(UNLOCK_COUNT);
    localparam logic [ADDR_W:0] FULL_LVL  = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    state_t              r_state;
    logic [7:0]          r_pos;
    logic [7:0]          r_hits;
    logic [7:0]          r_miss;
    logic                r_drop;
    logic                r_ovf;
    logic                r_sync_err;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [ADDR_W:0]     r_fill;
    logic [7:0]          r_data;
    logic [15:0]         r_mem [1 << ADDR_W];

    logic [7:0]          w_pos;
    logic                w_is_sync;
    logic                w_pkt_start;
    logic                w_try_wr;
    logic                w_unlock;
    logic                w_full;
    logic                w_rd_en;
    logic                w_wr_en;
    logic                w_ovf;
    logic [15:0]         w_head;

    // r_pos holds the position of the last accepted byte; w_pos is that of the current one
    assign w_pos       = (r_pos == PKT_LEN) ? 8'd1 : r_pos + 8'd1;
    assign w_is_sync   = (TS_DATA == SYNC_BYTE);
    assign w_pkt_start = (w_pos == 8'd1);

    always_comb begin
        w_try_wr = 1'b0;
        w_unlock = 1'b0;
        if (TS_VALID) begin
            case (r_state)
                VERIFY: w_try_wr = w_pkt_start && w_is_sync && (r_hits + 8'd1 == LOCK_N);
                LOCKED: begin
                    if (w_pkt_start && !w_is_sync && (r_miss + 8'd1 == UNLOCK_N))
                        w_unlock = 1'b1;
                    else
                        w_try_wr = !r_drop || (w_pkt_start && w_is_sync);
                end
                default: ;
            endcase
        end
    end

    // A read in the same cycle frees the slot, so a write at full is still accepted
    assign w_full  = (r_fill == FULL_LVL);
    assign w_rd_en = RD_REQ && (r_fill != '0);
    assign w_wr_en = w_try_wr && (!w_full || w_rd_en);
    assign w_ovf   = w_try_wr && w_full && !w_rd_en;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= SEARCH;
            r_pos      <= '0;
            r_hits     <= '0;
            r_miss     <= '0;
            r_drop     <= 1'b0;
            r_ovf      <= 1'b0;
            r_sync_err <= 1'b0;
        end else begin
            r_ovf      <= w_ovf;
            r_sync_err <= 1'b0;
            if (TS_VALID) begin
                case (r_state)
                    SEARCH: begin
                        if (w_is_sync) begin
                            r_state <= VERIFY;
                            r_pos   <= 8'd1;
                            r_hits  <= 8'd1;
                        end
                    end
                    VERIFY: begin
                        r_pos <= w_pos;
                        if (w_pkt_start) begin
                            if (w_is_sync) begin
                                r_hits <= r_hits + 8'd1;
                                if (r_hits + 8'd1 == LOCK_N) begin
                                    r_state <= LOCKED;
                                    r_miss  <= '0;
                                end
                            end else begin
                                r_state <= SEARCH;
                            end
                        end
                    end
                    LOCKED: begin
                        r_pos <= w_pos;
                        if (w_pkt_start) begin
                            if (w_is_sync) begin
                                r_miss <= '0;
                            end else begin
                                r_miss     <= r_miss + 8'd1;
                                r_sync_err <= 1'b1;
                                if (w_unlock)
                                    r_state <= SEARCH;
                            end
                        end
                    end
                    default: r_state <= SEARCH;
                endcase
            end
            // Writing resumes only on a packet start once a byte has been dropped
            if (w_ovf)
                r_drop <= 1'b1;
            else if (w_wr_en && w_pkt_start && w_is_sync)
                r_drop <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
            r_data   <= '0;
        end else begin
            if (w_wr_en)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_data   <= w_head[7:0];
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_fill <= r_fill + 1'b1;
                2'b01:   r_fill <= r_fill - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (w_wr_en)
            r_mem[r_wr_ptr] <= {w_pos, TS_DATA};
    end

    assign w_head     = r_mem[r_rd_ptr];
    assign DATA       = r_data;
    assign EMPTY      = (r_fill == '0);
    assign BYTE_INDEX = EMPTY ? '0 : w_head[15:8];
    assign SYNC_FOUND = (r_state == LOCKED);
    assign OVERFLOW   = r_ovf;
    assign SYNC_ERR   = r_sync_err;
    assign FILL_LEVEL = r_fill;

endmodule

// File: tb/tb_ts_input_sync_fifo.sv
// Directed bench for ts_input_sync_fifo: stimulus pushes expected {index,data} entries
// to a scoreboard queue, reads pop and compare them.
module tb_ts_input_sync_fifo;

    localparam int DEPTH = 2048;

    logic        CLK;
    logic        RST;
    logic [7:0]  TS_DATA;
    logic        TS_VALID;
    logic        RD_REQ;
    logic [7:0]  DATA;
    logic [7:0]  BYTE_INDEX;
    logic        EMPTY;
    logic        SYNC_FOUND;
    logic        OVERFLOW;
    logic        SYNC_ERR;
    logic [11:0] FILL_LEVEL;

    ts_input_sync_fifo #(.ADDR_W(11), .LOCK_COUNT(3), .UNLOCK_COUNT(3)) dut (
        .CLK(CLK), .RST(RST), .TS_DATA(TS_DATA), .TS_VALID(TS_VALID), .RD_REQ(RD_REQ),
        .DATA(DATA), .BYTE_INDEX(BYTE_INDEX), .EMPTY(EMPTY), .SYNC_FOUND(SYNC_FOUND),
        .OVERFLOW(OVERFLOW), .SYNC_ERR(SYNC_ERR), .FILL_LEVEL(FILL_LEVEL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int          n_pass = 0;
    int          n_total = 0;
    int          err_cnt = 0;
    int          ovf_cnt = 0;
    int          exp_err = 0;
    int          exp_ovf = 0;
    logic        mdrop = 1'b0;
    logic [7:0]  last_data = 8'h00;
    logic [15:0] sb[$];

    always @(negedge CLK) begin
        if (SYNC_ERR === 1'b1) err_cnt++;
        if (OVERFLOW === 1'b1) ovf_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [7:0] pay(input logic [7:0] seed, input int p);
        logic [7:0] v;
        v = seed + 8'(p);
        return (v == 8'h47) ? 8'h46 : v;
    endfunction

    // One clock: drive input byte / read request, model the FIFO write side, check the read.
    task automatic step(input logic v, input logic [7:0] d, input logic lk,
                        input logic [7:0] idx, input logic rd);
        logic [15:0] e;
        logic        do_rd;
        e = '0;
        TS_VALID = v;
        TS_DATA  = d;
        RD_REQ   = rd;
        do_rd = rd && (sb.size() != 0);
        if (do_rd) begin
            e = sb.pop_front();
            check("byte_index", 32'(BYTE_INDEX), 32'(e[15:8]));
        end
        if (v && lk && (!mdrop || (idx == 8'd1 && d == 8'h47))) begin
            if (sb.size() < DEPTH) begin
                sb.push_back({idx, d});
                if (idx == 8'd1 && d == 8'h47) mdrop = 1'b0;
            end else begin
                mdrop = 1'b1;
                exp_ovf++;
            end
        end
        tick;
        if (do_rd) begin
            check("read_data", 32'(DATA), 32'(e[7:0]));
            last_data = e[7:0];
        end
    endtask

    task automatic send_pkt(input logic [7:0] sync, input logic [7:0] seed,
                            input logic lk_sync, input logic lk_rest, input logic rd);
        step(1'b1, sync, lk_sync, 8'd1, rd);
        for (int p = 2; p <= 188; p++)
            step(1'b1, pay(seed, p - 1), lk_rest, 8'(p), rd);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 8'h00, 1'b0, 8'd0, 1'b1);
    endtask

    task automatic drain_all;
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 4096) begin
            step(1'b0, 8'h00, 1'b0, 8'd0, 1'b1);
            guard++;
        end
        step(1'b0, 8'h00, 1'b0, 8'd0, 1'b0);
        check("fill_after_drain", 32'(FILL_LEVEL), 32'd0);
    endtask

    initial begin
        RST = 1'b0; TS_VALID = 1'b0; TS_DATA = 8'h00; RD_REQ = 1'b0;
        tick; tick;
        RST = 1'b1;
        tick;
        check("rst_data", 32'(DATA), 32'h00);
        check("rst_empty", 32'(EMPTY), 32'd1);
        check("rst_sync_found", 32'(SYNC_FOUND), 32'd0);
        check("rst_overflow", 32'(OVERFLOW), 32'd0);
        check("rst_sync_err", 32'(SYNC_ERR), 32'd0);
        check("rst_fill", 32'(FILL_LEVEL), 32'd0);
        check("rst_byte_index", 32'(BYTE_INDEX), 32'd0);

        // 1: five clean packets, lock on the third
        send_pkt(8'h47, 8'h00, 1'b0, 1'b0, 1'b0);
        send_pkt(8'h47, 8'h00, 1'b0, 1'b0, 1'b0);
        check("t1_no_lock_after_2", 32'(SYNC_FOUND), 32'd0);
        check("t1_nothing_written", 32'(FILL_LEVEL), 32'd0);
        send_pkt(8'h47, 8'h00, 1'b1, 1'b1, 1'b0);
        check("t1_lock_after_3", 32'(SYNC_FOUND), 32'd1);
        send_pkt(8'h47, 8'h00, 1'b1, 1'b1, 1'b0);
        send_pkt(8'h47, 8'h00, 1'b1, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 8'd0, 1'b0);
        check("t1_fill_564", 32'(FILL_LEVEL), 32'd564);
        check("t1_head_index_1", 32'(BYTE_INDEX), 32'd1);
        drain(1);
        check("t1_first_data_47", 32'(DATA), 32'h47);
        check("t1_next_index_2", 32'(BYTE_INDEX), 32'd2);
        drain_all;

        // 2: two bad syncs keep lock, the third drops it; relock after three good syncs
        check("t2_err_none", 32'(err_cnt), 32'd0);
        send_pkt(8'h00, 8'h10, 1'b1, 1'b1, 1'b0); exp_err++;
        send_pkt(8'h00, 8'h20, 1'b1, 1'b1, 1'b0); exp_err++;
        check("t2_err_two", 32'(err_cnt), 32'(exp_err));
        check("t2_lock_kept", 32'(SYNC_FOUND), 32'd1);
        send_pkt(8'h00, 8'h30, 1'b0, 1'b0, 1'b0); exp_err++;
        check("t2_err_three", 32'(err_cnt), 32'(exp_err));
        check("t2_lock_lost", 32'(SYNC_FOUND), 32'd0);
        check("t2_no_write_after_loss", 32'(FILL_LEVEL), 32'(sb.size()));
        send_pkt(8'h47, 8'h40, 1'b0, 1'b0, 1'b0);
        send_pkt(8'h47, 8'h50, 1'b0, 1'b0, 1'b0);
        send_pkt(8'h47, 8'h60, 1'b1, 1'b1, 1'b0);
        check("t2_relocked", 32'(SYNC_FOUND), 32'd1);
        drain_all;

        // 4: one entry with a write and a read every cycle
        step(1'b1, 8'h47, 1'b1, 8'd1, 1'b1);
        check("t4_fill_one", 32'(FILL_LEVEL), 32'd1);
        for (int p = 2; p <= 188; p++) begin
            step(1'b1, pay(8'h70, p - 1), 1'b1, 8'(p), 1'b1);
            check("t4_fill_steady", 32'(FILL_LEVEL), 32'd1);
            check("t4_never_empty", 32'(EMPTY), 32'd0);
        end
        step(1'b0, 8'h00, 1'b0, 8'd0, 1'b1);
        check("t4_empty_end", 32'(EMPTY), 32'd1);
        step(1'b0, 8'h00, 1'b0, 8'd0, 1'b1);
        check("t4_data_held_on_empty", 32'(DATA), 32'(last_data));
        check("t4_fill_zero", 32'(FILL_LEVEL), 32'd0);

        // 3: overflow, drain 200, resume at next sync
        for (int k = 0; k < 10; k++)
            send_pkt(8'h47, 8'(k * 7), 1'b1, 1'b1, 1'b0);
        for (int p = 1; p <= 188; p++) begin
            step(1'b1, (p == 1) ? 8'h47 : pay(8'h99, p - 1), 1'b1, 8'(p), 1'b0);
            if (p == 168) check("t3_fill_full", 32'(FILL_LEVEL), 32'd2048);
            if (p == 169) begin
                check("t3_overflow_pulse", 32'(OVERFLOW), 32'd1);
                check("t3_fill_stays_full", 32'(FILL_LEVEL), 32'd2048);
                drain(200);
            end
        end
        send_pkt(8'h47, 8'hA0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 8'd0, 1'b0);
        check("t3_fill_after_resume", 32'(FILL_LEVEL), 32'(sb.size()));
        check("t3_overflow_count", 32'(ovf_cnt), 32'(exp_ovf));
        drain_all;

        // drop lock for the search test
        send_pkt(8'h00, 8'hB0, 1'b1, 1'b1, 1'b0); exp_err++;
        send_pkt(8'h00, 8'hB1, 1'b1, 1'b1, 1'b0); exp_err++;
        send_pkt(8'h00, 8'hB2, 1'b0, 1'b0, 1'b0); exp_err++;
        drain_all;
        check("t5_unlocked", 32'(SYNC_FOUND), 32'd0);

        // 5: stray 0x47 bytes at the wrong spacing
        for (int i = 0; i < 400; i++)
            step(1'b1, (i == 50 || i == 150) ? 8'h47 : 8'h11, 1'b0, 8'd0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 8'd0, 1'b0);
        check("t5_no_lock", 32'(SYNC_FOUND), 32'd0);
        check("t5_no_writes", 32'(FILL_LEVEL), 32'd0);
        check("t5_err_count", 32'(err_cnt), 32'(exp_err));

        // 6: reset mid-packet with 100 entries
        send_pkt(8'h47, 8'hC0, 1'b0, 1'b0, 1'b0);
        send_pkt(8'h47, 8'hC1, 1'b0, 1'b0, 1'b0);
        send_pkt(8'h47, 8'hC2, 1'b1, 1'b1, 1'b0);
        drain(98);
        step(1'b1, 8'h47, 1'b1, 8'd1, 1'b0);
        for (int p = 2; p <= 10; p++)
            step(1'b1, pay(8'hC3, p - 1), 1'b1, 8'(p), 1'b0);
        check("t6_fill_100", 32'(FILL_LEVEL), 32'd100);
        check("t6_locked", 32'(SYNC_FOUND), 32'd1);
        RST = 1'b0;
        #1;
        check("t6_rst_empty", 32'(EMPTY), 32'd1);
        check("t6_rst_sync_found", 32'(SYNC_FOUND), 32'd0);
        check("t6_rst_fill", 32'(FILL_LEVEL), 32'd0);
        check("t6_rst_data", 32'(DATA), 32'h00);
        sb.delete();
        mdrop = 1'b0;
        last_data = 8'h00;
        TS_VALID = 1'b0;
        #2;
        RST = 1'b1;
        tick;
        step(1'b0, 8'h00, 1'b0, 8'd0, 1'b1);
        check("t6_post_rst_empty", 32'(EMPTY), 32'd1);
        check("t6_post_rst_data", 32'(DATA), 32'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
